// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-link receive path.
// Holds the FSM state encoding and the default data width so that the
// transmit stage, the receiver and any bench agree on the same values.
package sipo_deserializer_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } sipo_state_e;

  // Even parity over a data word plus its received parity bit:
  // returns 1 when the total number of ones is odd (a mismatch).
  function automatic logic parity_mismatch(input logic [31:0] word, input logic par_bit);
    return (^word) ^ par_bit;
  endfunction

endpackage

// File: rtl/sipo_deserializer_rx_hold_reg.sv
// rx_hold_reg: 1-deep valid/ready output register for received words.
// A push loads the register when it is empty or being drained in the same
// cycle (no bubble); a push into a full, stalled register is dropped and
// raises the sticky overrun flag.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i             a completed word is offered this cycle
//   data_i, perr_i     the offered word and its parity-error flag
//   ready_i            consumer accepts data_o this cycle
//   ovr_clr_i          clears overrun_o (a simultaneous drop wins)
//   data_o, perr_o     held word and its parity-error flag
//   valid_o            held word not yet accepted
//   overrun_o          sticky: a completed word was dropped
module rx_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             perr_i,
  input  logic             ready_i,
  input  logic             ovr_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             perr_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             perr_q, perr_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic pop;
  logic accept;
  logic drop;

  always_comb begin
    pop    = valid_q && ready_i;
    accept = push_i && (!valid_q || ready_i);
    drop   = push_i && valid_q && !ready_i;

    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (accept) begin
      data_d  = data_i;
      perr_d  = perr_i;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end

    // Set has priority over clear so a drop is never lost.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign perr_o    = perr_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: receive stage for the serial link.
// Waits for a start bit '1' on an idle-low line, shifts in WIDTH data bits
// MSB-first, optionally checks an even-parity bit, and hands the word to a
// 1-deep valid/ready output register.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   serial_in_i         serial line, one bit per clock
//   out_ready_i         consumer accepts out_data_o this cycle
//   overrun_clr_i       clears overrun_o
//   out_data_o          received word, bit WIDTH-1 was received first
//   out_valid_o         out_data_o/out_parity_err_o hold an unaccepted word
//   out_parity_err_o    parity mismatch for out_data_o (0 without parity)
//   overrun_o           sticky: a completed word was dropped
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PARITY_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             serial_in_i,
  input  logic             out_ready_i,
  input  logic             overrun_clr_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  output logic             out_parity_err_o,
  output logic             overrun_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sipo_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;

  // Completed word, registered once so the hold register sees it one
  // cycle after the completing edge.
  logic             done_q, done_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wperr_q, wperr_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    word_d    = word_q;
    wperr_d   = wperr_q;

    unique case (state_q)
      IDLE: begin
        if (serial_in_i) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        shift_d   = {shift_q[WIDTH-2:0], serial_in_i};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          if (PARITY_EN != 0) begin
            state_d = PARITY;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            word_d  = {shift_q[WIDTH-2:0], serial_in_i};
            wperr_d = 1'b0;
          end
        end
      end

      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
        word_d  = shift_q;
        wperr_d = ^{shift_q, serial_in_i};
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      word_q    <= '0;
      wperr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      word_q    <= word_d;
      wperr_q   <= wperr_d;
    end
  end

  rx_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (done_q),
    .data_i    (word_q),
    .perr_i    (wperr_q),
    .ready_i   (out_ready_i),
    .ovr_clr_i (overrun_clr_i),
    .data_o    (out_data_o),
    .perr_o    (out_parity_err_o),
    .valid_o   (out_valid_o),
    .overrun_o (overrun_o)
  );

endmodule
